// File: rtl/rtc_read_seq_pkg.sv
// -----------------------------------------------------------------------------
// rtc_read_seq_pkg
// Constants shared by the RTC bus sequencers (read and write): the RTC
// register addresses, the bus frame length and the frame counter indices at
// which each strobe/drive event takes place.
// No ports (package).
// -----------------------------------------------------------------------------
package rtc_read_seq_pkg;

  localparam int CONT_W    = 6;   // frame counter width, holds 0..39
  localparam int IDX_W     = 2;   // register index width, holds 0..2
  localparam int FRAME_LEN = 40;

  // RTC register addresses
  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;

  // Value left on the bus whenever we are not driving an address
  localparam logic [7:0] BUS_IDLE  = 8'hFF;

  localparam logic [CONT_W-1:0] CONT_LAST = CONT_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = 2'd2;

  // Frame event indices: each is the first cont value at which the change
  // is visible on the pins.
  localparam logic [CONT_W-1:0] EV_AD_LO   = 6'd1;   // address latch low
  localparam logic [CONT_W-1:0] EV_CS_LO   = 6'd2;   // chip select, address phase
  localparam logic [CONT_W-1:0] EV_WR_LO   = 6'd3;
  localparam logic [CONT_W-1:0] EV_DRIVE   = 6'd4;   // address onto the bus
  localparam logic [CONT_W-1:0] EV_WR_HI   = 6'd9;
  localparam logic [CONT_W-1:0] EV_CS_HI   = 6'd10;
  localparam logic [CONT_W-1:0] EV_AD_HI   = 6'd11;
  localparam logic [CONT_W-1:0] EV_RELEASE = 6'd13;  // stop driving the bus
  localparam logic [CONT_W-1:0] EV_CS_LO2  = 6'd21;  // chip select, data phase
  localparam logic [CONT_W-1:0] EV_RD_LO   = 6'd22;
  localparam logic [CONT_W-1:0] EV_SAMPLE  = 6'd28;  // last cycle with rd low
  localparam logic [CONT_W-1:0] EV_RD_HI   = 6'd29;
  localparam logic [CONT_W-1:0] EV_CS_HI2  = 6'd30;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Address read in each frame of a burst: seg, min, hora.
  function automatic logic [7:0] read_addr(input logic [IDX_W-1:0] idx);
    case (idx)
      2'd0:    return ADDR_SEG;
      2'd1:    return ADDR_MIN;
      default: return ADDR_HORA;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_frame.sv
// -----------------------------------------------------------------------------
// rtc_bus_frame
// Pure decode of one 40-cycle RTC bus frame: given the frame counter and the
// register address, produces the strobe levels, bus drive value/enable and
// the ADin sample qualifier for that cycle. Holds no state.
// Ports:
//   i_cont   frame counter 0..39
//   i_addr   RTC register address for this frame
//   o_ad/o_cs/o_wr/o_rd  active-low RTC strobes
//   o_dout   bus drive value (8'hFF when not driving)
//   o_oe     bus drive enable
//   o_sample high in the cycle whose closing edge captures ADin
// -----------------------------------------------------------------------------
module rtc_bus_frame
  import rtc_read_seq_pkg::*;
(
  input  logic [CONT_W-1:0] i_cont,
  input  logic [7:0]        i_addr,
  output logic              o_ad,
  output logic              o_cs,
  output logic              o_wr,
  output logic              o_rd,
  output logic [7:0]        o_dout,
  output logic              o_oe,
  output logic              o_sample
);

  logic w_addr_phase;
  logic w_cs_addr;
  logic w_cs_data;

  assign w_addr_phase = (i_cont >= EV_DRIVE)  && (i_cont < EV_RELEASE);
  assign w_cs_addr    = (i_cont >= EV_CS_LO)  && (i_cont < EV_CS_HI);
  assign w_cs_data    = (i_cont >= EV_CS_LO2) && (i_cont < EV_CS_HI2);

  // The wr window (3..8) and the rd window (22..28) are disjoint, and the
  // drive window (4..12) ends well before rd falls, so bus contention is
  // impossible by construction.
  assign o_ad     = !((i_cont >= EV_AD_LO) && (i_cont < EV_AD_HI));
  assign o_cs     = !(w_cs_addr || w_cs_data);
  assign o_wr     = !((i_cont >= EV_WR_LO) && (i_cont < EV_WR_HI));
  assign o_rd     = !((i_cont >= EV_RD_LO) && (i_cont < EV_RD_HI));
  assign o_oe     = w_addr_phase;
  assign o_dout   = w_addr_phase ? i_addr : BUS_IDLE;
  assign o_sample = (i_cont == EV_SAMPLE);

endmodule

// File: rtl/rtc_read_seq.sv
// -----------------------------------------------------------------------------
// rtc_read_seq
// Reads seconds, minutes and hours from a multiplexed-bus RTC as one burst
// of three 40-cycle frames, then publishes all three bytes at once.
// Ports:
//   clock, reset        system clock (rising edge), async active-low reset
//   start               level request; a fresh rising edge launches a burst
//   ADin                RTC bus read value
//   ADout, ADoe         RTC bus drive value and drive enable
//   ad, cs, wr, rd      active-low RTC strobes
//   seg, min, hora      captured RTC bytes, updated together with done
//   busy                high while a burst is in progress
//   done                one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module rtc_read_seq
  import rtc_read_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ADin,
  output logic [7:0] ADout,
  output logic       ADoe,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic       busy,
  output logic       done
);

  state_t            r_state;
  logic [CONT_W-1:0] r_cont;
  logic [IDX_W-1:0]  r_idx;
  logic              r_start;
  logic              r_start_d;
  logic              r_armed;
  logic              r_sample;
  logic [7:0]        r_shadow [3];

  state_t            w_state_nxt;
  logic [CONT_W-1:0] w_cont_nxt;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_launch;
  logic              w_frame_end;
  logic              w_burst_end;
  logic              w_run_nxt;
  logic [7:0]        w_addr_nxt;
  logic              w_ad;
  logic              w_cs;
  logic              w_wr;
  logic              w_rd;
  logic              w_oe;
  logic              w_sample;
  logic [7:0]        w_dout;

  // r_armed only sets once start has actually been seen low after reset, so
  // a start held high across reset release cannot look like a new edge.
  assign w_launch    = (r_state == ST_IDLE) && r_armed && r_start && !r_start_d;
  assign w_frame_end = (r_cont == CONT_LAST);
  assign w_burst_end = (r_state == ST_RUN) && w_frame_end && (r_idx == IDX_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_cont_nxt  = r_cont;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt = ST_RUN;
          w_cont_nxt  = '0;
          w_idx_nxt   = '0;
        end
      end
      ST_RUN: begin
        if (w_frame_end) begin
          w_cont_nxt = '0;
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cont_nxt = r_cont + 1'b1;
        end
      end
    endcase
  end

  assign w_run_nxt  = (w_state_nxt == ST_RUN);
  assign w_addr_nxt = read_addr(w_idx_nxt);

  // The frame is decoded from the next counter value so that the registered
  // pins line up exactly with the cont value held in the same cycle.
  rtc_bus_frame u_frame (
    .i_cont   (w_cont_nxt),
    .i_addr   (w_addr_nxt),
    .o_ad     (w_ad),
    .o_cs     (w_cs),
    .o_wr     (w_wr),
    .o_rd     (w_rd),
    .o_dout   (w_dout),
    .o_oe     (w_oe),
    .o_sample (w_sample)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cont    <= '0;
      r_idx     <= '0;
      r_start   <= 1'b0;
      r_start_d <= 1'b0;
      r_armed   <= 1'b0;
      r_sample  <= 1'b0;
      // NOTE: the shadow bytes are cleared on reset so an aborted burst can
      // never leak partial data into a later publish.
      for (int i = 0; i < 3; i++) r_shadow[i] <= '0;
      ad    <= 1'b1;
      cs    <= 1'b1;
      wr    <= 1'b1;
      rd    <= 1'b1;
      ADoe  <= 1'b0;
      ADout <= BUS_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      seg   <= '0;
      min   <= '0;
      hora  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples the
      // pre-edge values regardless of statement order.
      r_start   <= start;
      r_start_d <= r_start;
      if (!start) r_armed <= 1'b1;

      r_state <= w_state_nxt;
      r_cont  <= w_cont_nxt;
      r_idx   <= w_idx_nxt;

      // Outside a burst the pins are forced to their idle levels.
      ad       <= w_run_nxt ? w_ad   : 1'b1;
      cs       <= w_run_nxt ? w_cs   : 1'b1;
      wr       <= w_run_nxt ? w_wr   : 1'b1;
      rd       <= w_run_nxt ? w_rd   : 1'b1;
      ADoe     <= w_run_nxt && w_oe;
      ADout    <= w_run_nxt ? w_dout : BUS_IDLE;
      r_sample <= w_run_nxt && w_sample;

      busy <= w_run_nxt;
      done <= w_burst_end;

      if (r_sample) r_shadow[r_idx] <= ADin;

      // All three bytes switch on the same edge as done.
      if (w_burst_end) begin
        seg  <= r_shadow[0];
        min  <= r_shadow[1];
        hora <= r_shadow[2];
      end
    end
  end

endmodule

// File: doc/rtc_read_seq.md
RTC_READ_SEQ -- requirements
Module: rtc_read_seq

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, level request; a rising edge launches one read burst.
REQ-004 SHALL have port ADin, input, 8, RTC multiplexed bus read value.
REQ-005 SHALL have port ADout, output, 8, RTC multiplexed bus drive value.
REQ-006 SHALL have port ADoe, output, 1, bus drive enable; 1 = ADout drives the pad.
REQ-007 SHALL have ports ad, cs, wr, rd, output, 1 each, active-low RTC strobes.
REQ-008 SHALL have ports seg, min, hora, output, 8 each, captured RTC bytes (BCD, passed through unmodified).
REQ-009 SHALL have port busy, output, 1, high from burst launch until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at burst completion.

Function
REQ-011 SHALL register start and launch a burst only on 0->1 of the registered value while busy=0; edges during busy are ignored and not queued.
REQ-012 SHALL read the fixed address list index 0..2 = 8'h21 (seg), 8'h22 (min), 8'h23 (hora), in that order.
REQ-013 SHALL run one 40-cycle frame per index, frame counter cont 0..39, counted from the cycle after launch.
REQ-014 SHALL in each frame apply: cont0 all strobes high; 1 ad=0; 2 cs=0; 3 wr=0; 4 ADout=address, ADoe=1; 9 wr=1; 10 cs=1; 11 ad=1; 13 ADoe=0, ADout=8'hFF; 21 cs=0; 22 rd=0; 28 sample ADin into shadow[index]; 29 rd=1; 30 cs=1; 31-39 idle.
REQ-015 SHALL never have wr=0 and rd=0 simultaneously, and never have ADoe=1 while rd=0.
REQ-016 SHALL at cont=39 increment index, or after index 2 clear cont/index, return to idle, and assert done for exactly one cycle.
REQ-017 SHALL copy all three shadow bytes to seg/min/hora in the same cycle as done, so consumers never see a mixed old/new triple.
REQ-018 SHALL hold seg/min/hora stable between done pulses.
REQ-019 SHALL drive in idle: ad=cs=wr=rd=1, ADoe=0, ADout=8'hFF, busy=0.
REQ-020 SHALL set busy=1 the cycle after the launching edge and clear it in the done cycle; burst length 120 cycles from busy rise to done.
REQ-021 SHALL accept a new start edge from the cycle after done (start must fall and rise again).
REQ-022 SHALL use FSM states IDLE -> RUN -> IDLE; RUN is subdivided only by cont and index.

Reset
REQ-023 SHALL on reset=0, asynchronously: ad=cs=wr=rd=1, ADoe=0, ADout=8'hFF, busy=0, done=0, seg=min=hora=8'h00, shadows=0, cont=0, index=0, start register=0, state IDLE.
REQ-024 SHALL on reset assertion mid-burst abort immediately, release the bus, discard the partial shadows and leave outputs at reset values.
REQ-025 SHALL require a fresh start rising edge after reset release; start held high through reset does not launch.

Structure
REQ-026 SHALL place the RTC address constants (8'h21/22/23), frame length 40 and the cont event indices in a shared package also used by the RTC write sequencer.
REQ-027 SHALL implement the per-frame strobe/drive decode in one sub-module rtc_bus_frame (inputs cont, address; outputs strobes, ADout, ADoe, sample), leaving index/burst control in the top.

Verification
REQ-028 SHALL check: reset low then high, start 0->1, RTC model returns 8'h45/8'h30/8'h12 -> done at cycle 121 after the edge, seg=45, min=30, hora=12, busy high exactly 120 cycles.
REQ-029 SHALL check: per-frame strobe trace against REQ-014 cycle by cycle for address 8'h22, plus assertions for REQ-015 throughout.
REQ-030 SHALL check: second start edge at cycle 50 of a burst -> ignored, exactly one done pulse, no second burst.
REQ-031 SHALL check: reset low at cont=25 of index 1 -> all outputs at reset values in the same cycle, seg/min/hora stay 8'h00, no done pulse.
REQ-032 SHALL check: burst 1 returns 59/59/23, burst 2 returns 00/00/00 -> outputs stay 59/59/23 until burst 2 done cycle, then switch all three together.
REQ-033 SHALL check: start held high across reset release -> no burst until start toggles low then high.
